// File: rtl/flash_sample_reader_pkg.sv
// Shared definitions for the flash sample reader and its address counter.
// The direction constants are also used by the keyboard FSM.
package flash_sample_reader_pkg;

  localparam int                DEF_ADDR_W   = 23;
  localparam logic [22:0]       DEF_MAX_ADDR = 23'h7FFFF;
  localparam int                DEF_SAMPLE_W = 16;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_BWD = 1'b0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2,
    EMIT      = 2'd3
  } state_e;

endpackage

// File: rtl/flash_addr_counter.sv
// Up/down flash word-address counter.
// It wraps at 0 and MAX_ADDR, and can jump to the song start for either direction.
module flash_addr_counter
  import flash_sample_reader_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = DEF_MAX_ADDR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              start_dir,
  input  logic              step,
  input  logic              step_dir,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] addr_d, addr_q;

  // A load takes priority over a step. The address wraps at both ends.
  always_comb begin
    addr_d = addr_q;
    if (load_start) begin
      addr_d = (start_dir == DIR_FWD) ? '0 : MAX_ADDR;
    end else if (step) begin
      if (step_dir == DIR_FWD) begin
        addr_d = (addr_q == MAX_ADDR) ? '0 : addr_q + ADDR_W'(1);
      end else begin
        addr_d = (addr_q == '0) ? MAX_ADDR : addr_q - ADDR_W'(1);
      end
    end
  end

  // Address register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) addr_q <= '0;
    else          addr_q <= addr_d;
  end

  assign addr = addr_q;

endmodule

// File: rtl/flash_sample_reader.sv
// Reads 32-bit audio words from flash through an Avalon-MM read master.
// It plays out one 16-bit half-word per sample tick, in either direction.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a tick; with half=1 the stored word still has a sample to play
// REQ       | flash_read asserted, address held until waitrequest drops
// WAIT_DATA | request accepted, waiting for readdatavalid
// EMIT      | one-cycle sample_valid pulse, then back to IDLE
module flash_sample_reader
  import flash_sample_reader_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = DEF_MAX_ADDR,
  parameter int                SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_tick,
  input  logic                start_reading,
  input  logic                direction,
  input  logic                restart,
  output logic [ADDR_W-1:0]   flash_address,
  output logic                flash_read,
  input  logic                flash_waitrequest,
  input  logic [31:0]         flash_readdata,
  input  logic                flash_readdatavalid,
  output logic [SAMPLE_W-1:0] audio_sample,
  output logic                sample_valid
);

  state_e              state_d, state_q;
  logic                flash_read_d, flash_read_q;
  logic                half_d, half_q;
  logic                restart_pend_d, restart_pend_q;
  logic                dir_latched_d, dir_latched_q;
  logic [31:0]         word_d, word_q;
  logic [SAMPLE_W-1:0] audio_sample_d, audio_sample_q;
  logic                sample_valid_d, sample_valid_q;
  logic                cnt_load, cnt_step;

  flash_addr_counter #(
    .ADDR_W   (ADDR_W),
    .MAX_ADDR (MAX_ADDR)
  ) u_addr_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_start (cnt_load),
    .start_dir  (direction),
    .step       (cnt_step),
    .step_dir   (dir_latched_q),
    .addr       (flash_address)
  );

  // Next-state logic. The first sample is loaded straight from readdata, so sample_valid
  // rises one cycle after readdatavalid. A second-half tick is answered the same way.
  always_comb begin
    state_d        = state_q;
    flash_read_d   = flash_read_q;
    half_d         = half_q;
    restart_pend_d = restart_pend_q;
    dir_latched_d  = dir_latched_q;
    word_d         = word_q;
    audio_sample_d = audio_sample_q;
    sample_valid_d = 1'b0;
    cnt_load       = 1'b0;
    cnt_step       = 1'b0;

    case (state_q)
      IDLE: begin
        if (restart) begin
          cnt_load = 1'b1;
          half_d   = 1'b0;
        end else if (sample_tick && start_reading) begin
          if (!half_q) begin
            state_d      = REQ;
            flash_read_d = 1'b1;
          end else begin
            audio_sample_d = (dir_latched_q == DIR_FWD) ? word_q[2*SAMPLE_W-1:SAMPLE_W]
                                                        : word_q[SAMPLE_W-1:0];
            sample_valid_d = 1'b1;
            half_d         = 1'b0;
            cnt_step       = 1'b1;
            state_d        = EMIT;
          end
        end
      end

      REQ: begin
        if (restart) restart_pend_d = 1'b1;
        if (!flash_waitrequest) begin
          flash_read_d = 1'b0;
          state_d      = WAIT_DATA;
        end
      end

      WAIT_DATA: begin
        if (flash_readdatavalid) begin
          if (restart_pend_q || restart) begin
            // The fetched word belongs to the old position, so it is dropped.
            cnt_load       = 1'b1;
            half_d         = 1'b0;
            restart_pend_d = 1'b0;
            state_d        = IDLE;
          end else begin
            word_d         = flash_readdata;
            dir_latched_d  = direction;
            audio_sample_d = (direction == DIR_FWD) ? flash_readdata[SAMPLE_W-1:0]
                                                    : flash_readdata[2*SAMPLE_W-1:SAMPLE_W];
            sample_valid_d = 1'b1;
            half_d         = 1'b1;
            state_d        = EMIT;
          end
        end else if (restart) begin
          restart_pend_d = 1'b1;
        end
      end

      EMIT: begin
        state_d = IDLE;
        if (restart) begin
          cnt_load = 1'b1;
          half_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. The async clear also drops flash_read immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      flash_read_q   <= 1'b0;
      half_q         <= 1'b0;
      restart_pend_q <= 1'b0;
      dir_latched_q  <= DIR_FWD;
      word_q         <= '0;
      audio_sample_q <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      flash_read_q   <= flash_read_d;
      half_q         <= half_d;
      restart_pend_q <= restart_pend_d;
      dir_latched_q  <= dir_latched_d;
      word_q         <= word_d;
      audio_sample_q <= audio_sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign flash_read   = flash_read_q;
  assign audio_sample = audio_sample_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Testbench for flash_sample_reader.
// Expected samples are queued when the read data is driven and compared whenever
// sample_valid pulses.
module tb_flash_sample_reader;

  logic        clk;
  logic        reset_n;
  logic        sample_tick;
  logic        start_reading;
  logic        direction;
  logic        restart;
  logic [22:0] flash_address;
  logic        flash_read;
  logic        flash_waitrequest;
  logic [31:0] flash_readdata;
  logic        flash_readdatavalid;
  logic [15:0] audio_sample;
  logic        sample_valid;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          valid_cnt = 0;
  logic [15:0] exp_q[$];
  logic [22:0] cur_addr;
  logic [31:0] wd;
  int          vc0;

  flash_sample_reader dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .sample_tick         (sample_tick),
    .start_reading       (start_reading),
    .direction           (direction),
    .restart             (restart),
    .flash_address       (flash_address),
    .flash_read          (flash_read),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid),
    .audio_sample        (audio_sample),
    .sample_valid        (sample_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Scoreboard: every sample_valid pulse must match the oldest queued sample.
  always @(negedge clk) begin
    if (reset_n && sample_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) chk("spurious_valid", 32'(audio_sample), 32'hFFFF_FFFF);
      else                   chk("sample", 32'(audio_sample), 32'(exp_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full first-half fetch: tick, request with nwait stalls, nlat idle cycles, data.
  task automatic fetch(input logic [22:0] a, input logic [31:0] d, input int nwait,
                       input int nlat, input logic dir);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("fetch_read", 32'(flash_read), 32'd1);
    chk("fetch_addr", 32'(flash_address), 32'(a));
    flash_waitrequest = 1'b1;
    repeat (nwait) begin
      step();
      chk("req_hold_read", 32'(flash_read), 32'd1);
      chk("req_hold_addr", 32'(flash_address), 32'(a));
    end
    flash_waitrequest = 1'b0;
    step();
    chk("read_drop", 32'(flash_read), 32'd0);
    repeat (nlat) step();
    flash_readdata      = d;
    flash_readdatavalid = 1'b1;
    exp_q.push_back(dir ? d[15:0] : d[31:16]);
    step();
    flash_readdatavalid = 1'b0;
    step();
  endtask

  task automatic second_half(input logic [15:0] s);
    exp_q.push_back(s);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
  endtask

  initial begin
    reset_n             = 1'b0;
    sample_tick         = 1'b0;
    start_reading       = 1'b1;
    direction           = 1'b1;
    restart             = 1'b0;
    flash_waitrequest   = 1'b0;
    flash_readdata      = '0;
    flash_readdatavalid = 1'b0;
    #1;
    chk("rst_addr",   32'(flash_address), 32'd0);
    chk("rst_read",   32'(flash_read),    32'd0);
    chk("rst_sample", 32'(audio_sample),  32'd0);
    chk("rst_valid",  32'(sample_valid),  32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Forward fetch with a stalled request.
    fetch(23'd0, 32'hAAAA5555, 3, 2, 1'b1);
    second_half(16'hAAAA);
    chk("fwd_step_addr", 32'(flash_address), 32'd1);

    // Restart in IDLE moves to 0 going forward. A tick in the same cycle is ignored.
    restart     = 1'b1;
    sample_tick = 1'b1;
    step();
    restart     = 1'b0;
    sample_tick = 1'b0;
    chk("restart_idle_addr", 32'(flash_address), 32'd0);
    chk("restart_tick_ignored", 32'(flash_read), 32'd0);
    step();

    // Backward from 0 wraps to MAX_ADDR.
    direction = 1'b0;
    fetch(23'd0, 32'h12345678, 0, 1, 1'b0);
    second_half(16'h5678);
    chk("bwd_wrap_addr", 32'(flash_address), 32'h7FFFF);

    // Forward from MAX_ADDR wraps to 0.
    direction = 1'b1;
    fetch(23'h7FFFF, 32'h0BADF00D, 1, 0, 1'b1);
    second_half(16'h0BAD);
    chk("fwd_wrap_addr", 32'(flash_address), 32'd0);

    // Pause between halves: ticks are ignored and the output holds.
    fetch(23'd0, 32'h11112222, 0, 0, 1'b1);
    start_reading = 1'b0;
    vc0 = valid_cnt;
    repeat (3) begin
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      chk("pause_no_read", 32'(flash_read), 32'd0);
      step();
    end
    chk("pause_sample_held", 32'(audio_sample), 32'h2222);
    chk("pause_addr_held", 32'(flash_address), 32'd0);
    chk("pause_no_valid", 32'(valid_cnt), 32'(vc0));
    start_reading = 1'b1;
    second_half(16'h1111);
    chk("resume_addr", 32'(flash_address), 32'd1);

    // Walk forward to 0x100.
    cur_addr = 23'd1;
    while (cur_addr != 23'h100) begin
      wd = {cur_addr[15:0] ^ 16'hA5A5, cur_addr[15:0]};
      fetch(cur_addr, wd, 0, 0, 1'b1);
      second_half(wd[31:16]);
      cur_addr = cur_addr + 23'd1;
    end
    chk("walk_addr", 32'(flash_address), 32'h100);

    // Restart during WAIT_DATA: the returned word is dropped and the address goes to 0.
    vc0 = valid_cnt;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("rs_fetch_addr", 32'(flash_address), 32'h100);
    flash_waitrequest = 1'b0;
    step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    step();
    flash_readdata      = 32'hCAFEBABE;
    flash_readdatavalid = 1'b1;
    step();
    flash_readdatavalid = 1'b0;
    step();
    step();
    chk("rs_no_valid", 32'(valid_cnt), 32'(vc0));
    chk("rs_addr", 32'(flash_address), 32'd0);
    chk("rs_read_idle", 32'(flash_read), 32'd0);
    // With half cleared, the next tick fetches a new word.
    fetch(23'd0, 32'h55AA33CC, 0, 0, 1'b1);
    second_half(16'h55AA);

    // Ticks on every cycle while a fetch is in flight give exactly one sample.
    vc0 = valid_cnt;
    sample_tick = 1'b1;
    step();
    chk("burst_fetch_addr", 32'(flash_address), 32'd1);
    flash_waitrequest = 1'b0;
    step();
    repeat (4) step();
    flash_readdata      = 32'hDEADBEEF;
    flash_readdatavalid = 1'b1;
    exp_q.push_back(16'hBEEF);
    step();
    flash_readdatavalid = 1'b0;
    step();
    sample_tick = 1'b0;
    step();
    chk("burst_one_valid", 32'(valid_cnt), 32'(vc0 + 1));
    chk("burst_no_refetch", 32'(flash_read), 32'd0);
    second_half(16'hDEAD);
    chk("burst_addr", 32'(flash_address), 32'd2);

    // Async reset during REQ drops flash_read before the next edge.
    vc0 = valid_cnt;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("ar_read_up", 32'(flash_read), 32'd1);
    flash_waitrequest = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_read_async", 32'(flash_read), 32'd0);
    chk("ar_addr_async", 32'(flash_address), 32'd0);
    step();
    reset_n = 1'b1;
    flash_waitrequest = 1'b0;
    step();
    flash_readdata      = 32'h87654321;
    flash_readdatavalid = 1'b1;
    step();
    flash_readdatavalid = 1'b0;
    step();
    chk("ar_late_valid_ignored", 32'(valid_cnt), 32'(vc0));
    chk("ar_idle_read", 32'(flash_read), 32'd0);
    fetch(23'd0, 32'h0F0FF0F0, 0, 0, 1'b1);
    second_half(16'h0F0F);

    step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/flash_sample_reader.md
Name: flash_sample_reader

Overview:
- Consumer end of the keyboard control interface: takes `start_reading` (play/pause) and `direction` (fwd/back) from the keyboard FSM.
- Fetches 32-bit audio words from the on-board flash over an Avalon-MM read master.
- Emits one 16-bit sample per audio-rate tick to the audio path.
- Sits between the keyboard FSM and flash controller (upstream) and the audio DAC path (downstream).

Parameters:
- ADDR_W, 23, flash word-address width.
- MAX_ADDR, 23'h7FFFF, last word address of the song; address space wraps at this bound.
- SAMPLE_W, 16, width of one audio sample (two per 32-bit word).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
- sample_tick  input  1  one-cycle pulse at the audio sample rate, synchronous to clk.
- start_reading  input  1  1 = play, 0 = pause (level, from keyboard FSM).
- direction  input  1  1 = forward, 0 = backward (level, from keyboard FSM).
- restart  input  1  one-cycle pulse: jump to the song start for the current direction.
- flash_address  output  ADDR_W  Avalon word address.
- flash_read  output  1  Avalon read request.
- flash_waitrequest  input  1  Avalon stall.
- flash_readdata  input  32  Avalon read data.
- flash_readdatavalid  input  1  Avalon read data valid.
- audio_sample  output  SAMPLE_W  current sample; holds its value between updates.
- sample_valid  output  1  one-cycle pulse when audio_sample updates.

Behaviour:
- Reset values: flash_address=0, flash_read=0, audio_sample=0, sample_valid=0, half=0, restart_pend=0, state=IDLE.
- States: IDLE, REQ, WAIT_DATA, EMIT.
- IDLE, tick with start_reading=1 and half=0: go to REQ. flash_read=1 and flash_address is driven with the current address.
- IDLE, tick with start_reading=1 and half=1: go to EMIT using the stored word's second sample.
- IDLE, tick with start_reading=0: ignored; audio_sample holds; address and half are unchanged.
- REQ: flash_read and flash_address are held stable while waitrequest=1. On a cycle with waitrequest=0, the request is accepted; flash_read drops the next cycle and the block goes to WAIT_DATA.
- WAIT_DATA: wait for readdatavalid, then latch the word and dir_latched=direction, and go to EMIT. There is no timeout.
- EMIT (one cycle): load audio_sample and pulse sample_valid. Returns to IDLE.
  - Sample order when dir_latched=1: [15:0] first, then [31:16].
  - Sample order when dir_latched=0: [31:16] first, then [15:0].
  - After the first sample: half=1.
  - After the second sample: half=0. The address steps +1 (dir_latched=1) or -1 (dir_latched=0).
- Wrap: forward from MAX_ADDR goes to 0; backward from 0 goes to MAX_ADDR.
- Latency:
  - Tick at cycle t → flash_read=1 at t+1.
  - Accept at t+1, readdatavalid at t+k → sample_valid at t+k+1.
  - Second-half tick at cycle u → sample_valid at u+1.
- Ticks arriving in REQ, WAIT_DATA or EMIT are dropped; they are not queued.
- A direction change mid-word takes effect at the next word fetch. The current word finishes in the latched order.
- A pause mid-fetch lets the fetch and its first-sample EMIT complete; nothing further happens until play resumes.
- Restart in IDLE: address = 0 if direction=1, MAX_ADDR if direction=0; half=0. A tick in the same cycle is ignored (restart wins).
- Restart in REQ or WAIT_DATA: sets restart_pend.
  - REQ must still complete its handshake.
  - The returned word is discarded: no EMIT, no sample_valid.
  - The restart is then applied and the block returns to IDLE.
- Reset asserted mid-transaction: all state clears immediately and flash_read drops asynchronously. A late readdatavalid after reset is ignored in IDLE.
- Readdatavalid outside WAIT_DATA is ignored.

Decomposition:
- Shared package: state encoding (IDLE/REQ/WAIT_DATA/EMIT), MAX_ADDR, direction constants (DIR_FWD=1, DIR_BWD=0). The keyboard FSM uses the same direction constants.
- One natural sub-module: flash_addr_counter (up/down wrap counter with load-start and step inputs).

Test Plan:
- Reset, play, fwd; tick; waitrequest=1 for 3 cycles, then 0; readdatavalid with 32'hAAAA5555 → address 0 held stable, sample 16'h5555. Next tick → 16'hAAAA, address becomes 1.
- Backward at address 0, word 32'h12345678 → samples 16'h1234 then 16'h5678; address wraps to 23'h7FFFF.
- Forward at 23'h7FFFF, two ticks → address wraps to 0.
- start_reading=0 between ticks → no flash_read, no sample_valid; audio_sample held.
- Restart pulse during WAIT_DATA (fwd, address 23'h100) → returned word produces no sample_valid; address=0, half=0.
- Ticks every cycle while in WAIT_DATA → exactly one sample_valid per completed fetch. Async reset mid-REQ → flash_read=0 in the same cycle.
